dense_mac_seq: RTL and testbench
================================

Name: dense_mac_seq

Overview:
Sequencer and multiply-accumulate engine for a fully connected layer. It sits directly downstream of the dense weight ROM and the flattened-activation buffer. It walks both memories neuron by neuron, accumulates offset-corrected products, and hands one signed sum per output neuron to the next stage through a valid/ready handshake.

Parameters:
NUM_INPUTS, 169, activations per neuron (flattened feature length)
NUM_NEURONS, 3, output neurons; weight ROM depth = NUM_INPUTS*NUM_NEURONS = 507
addressWidthDense, 10, weight ROM address width
addressWidthAct, 8, activation buffer address width
dataWidthDense, 8, weight and activation width
ACC_WIDTH, 24, signed accumulator/output width
offset_ent, 1, signed zero-point correction added to each activation before multiply

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to process one input vector; ignored unless idle
busy  out  1  high from accepted start until done pulse inclusive
done  out  1  one-cycle pulse after the last neuron result is accepted
w_en  out  1  weight ROM read enable
w_addr  out  addressWidthDense  weight ROM address
w_data  in  dataWidthDense  weight ROM data, valid 1 cycle after w_en (registered read, ROM applies its own filter offset)
a_en  out  1  activation buffer read enable
a_addr  out  addressWidthAct  activation address
a_data  in  dataWidthDense  activation data, unsigned, valid 1 cycle after a_en
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_idx  out  2  neuron index of current result (width = clog2(NUM_NEURONS))
out_data  out  ACC_WIDTH  signed accumulated sum

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, w_en, a_en, out_valid = 0; w_addr, a_addr, out_idx, out_data, accumulator, counters = 0. Reset mid-operation aborts immediately. No result or done is produced for the aborted vector.
- States: IDLE, RUN, LAST, OUT, DONE.
- IDLE: if start=1, then i=0, n=0, base=0, acc=0, busy=1, next RUN.
- RUN: each cycle w_en=a_en=1, w_addr=base+i, a_addr=i. A registered flag pend=1 marks data arriving next cycle. When i=NUM_INPUTS-1, next LAST; otherwise i+1.
- MAC: in any cycle where pend=1, acc <= acc + sext(($signed({1'b0,a_data}) + offset_ent) * $signed(w_data)).
  - The activation term is 10-bit signed and the weight is 8-bit signed. The 18-bit product is sign-extended to ACC_WIDTH.
  - Two's-complement wrap on overflow; no saturation.
- LAST: w_en=a_en=0; the final product is accumulated this cycle. Next OUT.
- OUT: out_valid=1, out_data=acc, out_idx=n, all held stable until out_ready=1.
  - On the cycle out_valid && out_ready: if n=NUM_NEURONS-1, next DONE. Otherwise n+1, base+=NUM_INPUTS (adder, no multiplier), i=0, acc=0, next RUN.
  - out_valid drops the cycle after acceptance.
- DONE: done=1 for one cycle, busy=1; next IDLE with busy=0.
- No memory reads are issued outside RUN. w_addr never exceeds NUM_INPUTS*NUM_NEURONS-1; a_addr never exceeds NUM_INPUTS-1.
- Latency per neuron: NUM_INPUTS+2 cycles from first read to out_valid. Total with out_ready tied high: NUM_NEURONS*(NUM_INPUTS+2)+1 cycles to done (513+1 default).
- start while busy: ignored and not queued. start coincident with the done pulse: ignored.
- out_ready while out_valid=0: no effect.

Test Plan:
- All weights 0x01, all activations 0x00, offset_ent=1, out_ready=1 -> three results, out_idx 0,1,2, each out_data=169; done pulses once, 514 cycles after start.
- Weights 0xFF (-1), activations 0xFF -> each out_data = -256*169 = -43264 (0xFF5700 at 24 bits).
- Neuron-dependent ROM (neuron n weights = n+1), activations = 1 -> out_data 338, 676, 1014. Check w_addr sequences 0..168, 169..337, 338..506; a_addr 0..168 repeated three times.
- out_ready held low 10 cycles at each OUT -> out_valid and out_data stable, w_en=a_en=0 throughout, results unchanged, done delayed by 30 cycles.
- start pulsed again during RUN of neuron 1 -> ignored; exactly three results and one done.
- rst_n asserted mid-RUN of neuron 1 -> all outputs 0 immediately. A new start then yields a clean three-result sequence matching the first scenario.

Source files
------------

// File: rtl/dense_mac_seq.sv
// Dense-layer sequencer: walks weight ROM and activation buffer neuron by neuron,
// accumulates offset-corrected signed products and emits one sum per neuron via valid/ready.
module dense_mac_seq #(
    parameter int NUM_INPUTS        = 169,
    parameter int NUM_NEURONS       = 3,
    parameter int addressWidthDense = 10,
    parameter int addressWidthAct   = 8,
    parameter int dataWidthDense    = 8,
    parameter int ACC_WIDTH         = 24,
    parameter int offset_ent        = 1,
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         w_en,
    output logic [addressWidthDense-1:0] w_addr,
    input  logic [dataWidthDense-1:0]    w_data,
    output logic                         a_en,
    output logic [addressWidthAct-1:0]   a_addr,
    input  logic [dataWidthDense-1:0]    a_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_idx,
    output logic [ACC_WIDTH-1:0]         out_data
);

    localparam int ACT_W  = dataWidthDense + 2;
    localparam int PROD_W = ACT_W + dataWidthDense;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LAST,
        S_OUT,
        S_DONE
    } state_t;

    state_t                       state, state_n;
    logic [addressWidthAct-1:0]   i;
    logic [IDX_W-1:0]             n;
    logic [addressWidthDense-1:0] base;
    logic [ACC_WIDTH-1:0]         acc;
    logic                         pend;

    logic signed [ACT_W-1:0]      act_term;
    logic signed [PROD_W-1:0]     prod;
    logic [ACC_WIDTH-1:0]         prod_ext;
    logic                         last_i;
    logic                         last_n;

    assign last_i = (i == addressWidthAct'(NUM_INPUTS - 1));
    assign last_n = (n == IDX_W'(NUM_NEURONS - 1));

    // Zero-extend the unsigned activation before adding the signed zero-point.
    assign act_term = $signed({2'b00, a_data}) + ACT_W'(offset_ent);
    assign prod     = PROD_W'(act_term) * PROD_W'($signed(w_data));
    assign prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign w_en      = (state == S_RUN);
    assign a_en      = (state == S_RUN);
    assign w_addr    = base + addressWidthDense'(i);
    assign a_addr    = i;
    assign out_valid = (state == S_OUT);
    assign out_idx   = n;
    assign out_data  = out_valid ? acc : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = S_RUN;
            S_RUN:  if (last_i) state_n = S_LAST;
            S_LAST: state_n = S_OUT;
            S_OUT:  if (out_ready) state_n = last_n ? S_DONE : S_RUN;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // The read issued in the final RUN cycle lands during LAST, so pend covers it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i    <= '0;
            n    <= '0;
            base <= '0;
            acc  <= '0;
            pend <= 1'b0;
        end else begin
            pend <= (state == S_RUN);
            if (pend) acc <= acc + prod_ext;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        i    <= '0;
                        n    <= '0;
                        base <= '0;
                        acc  <= '0;
                    end
                end
                S_RUN: begin
                    if (!last_i) i <= i + 1'b1;
                end
                S_OUT: begin
                    if (out_ready && !last_n) begin
                        n    <= n + 1'b1;
                        base <= base + addressWidthDense'(NUM_INPUTS);
                        i    <= '0;
                        acc  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_mac_seq.sv
// Bench for dense_mac_seq: registered-read memory models, a per-neuron sum model,
// and a negedge compare process over reads, results and done.
module tb_dense_mac_seq;

    localparam int NI   = 169;
    localparam int NN   = 3;
    localparam int ACCW = 24;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, w_en, a_en, out_valid;
    logic        out_ready = 1'b1;
    logic [9:0]  w_addr;
    logic [7:0]  a_addr;
    logic [7:0]  w_data = '0;
    logic [7:0]  a_data = '0;
    logic [1:0]  out_idx;
    logic [ACCW-1:0] out_data;

    logic [7:0]  wmem [0:NI*NN-1];
    logic [7:0]  amem [0:NI-1];

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    int n_res = 0;
    int n_done = 0;
    int wait_cnt = 0;
    bit checking = 1'b0;
    bit stall_mode = 1'b0;
    logic [ACCW-1:0] exp_res [0:NN-1];
    logic [ACCW-1:0] got [0:NN-1];

    dense_mac_seq #(
        .NUM_INPUTS(NI),
        .NUM_NEURONS(NN),
        .addressWidthDense(10),
        .addressWidthAct(8),
        .dataWidthDense(8),
        .ACC_WIDTH(ACCW),
        .offset_ent(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .a_en(a_en), .a_addr(a_addr), .a_data(a_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_en) w_data <= wmem[w_addr];
        if (a_en) a_data <= amem[a_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_mem(input int mode);
        for (int k = 0; k < NI*NN; k++) begin
            case (mode)
                0: wmem[k] = 8'h01;
                1: wmem[k] = 8'hFF;
                default: wmem[k] = 8'(k / NI + 1);
            endcase
        end
        for (int k = 0; k < NI; k++) begin
            case (mode)
                0: amem[k] = 8'h00;
                1: amem[k] = 8'hFF;
                default: amem[k] = 8'h01;
            endcase
        end
        // Reference sums straight from the arithmetic definition.
        for (int nn = 0; nn < NN; nn++) begin
            int s;
            s = 0;
            for (int k = 0; k < NI; k++)
                s += (int'(amem[k]) + 1) * int'($signed(wmem[nn*NI + k]));
            exp_res[nn] = ACCW'(s);
        end
    endtask

    // Downstream ready: in stall mode hold off each result for 10 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!out_valid) begin
                wait_cnt  = 0;
                out_ready = !stall_mode;
            end else if (stall_mode && wait_cnt < 10) begin
                out_ready = 1'b0;
                wait_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && checking) begin
                if (w_en || a_en) begin
                    check("en_match", 32'(w_en), 32'(a_en));
                    check("w_addr", 32'(w_addr), rd_cnt);
                    check("a_addr", 32'(a_addr), rd_cnt % NI);
                    rd_cnt++;
                end
                if (out_valid) begin
                    check("no_read_in_out", 32'(w_en), 0);
                    if (n_res < NN) begin
                        check("out_idx", 32'(out_idx), n_res);
                        check("out_data", 32'(out_data), 32'(exp_res[n_res]));
                        if (out_ready) begin
                            got[n_res] = out_data;
                            n_res++;
                        end
                    end else begin
                        check("extra_result", n_res, NN - 1);
                    end
                end
                if (done) begin
                    check("results_before_done", n_res, NN);
                    n_done++;
                end
            end
        end
    end

    task automatic begin_vector;
        rd_cnt   = 0;
        n_res    = 0;
        n_done   = 0;
        checking = 1'b1;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic run_vector(input int exp_cycles, input bit extra_start, input string tag);
        int cyc;
        begin_vector();
        cyc = 1;
        forever begin
            @(negedge clk);
            if (done || cyc >= 2000) break;
            @(posedge clk);
            #1;
            cyc++;
            start = extra_start && (cyc == 250);
        end
        start = 1'b0;
        check({"done_latency_", tag}, cyc, exp_cycles);
        @(posedge clk);
        #1;
        check({"busy_after_done_", tag}, 32'(busy), 0);
        check({"done_one_cycle_", tag}, 32'(done), 0);
        repeat (5) @(posedge clk);
        #1;
        check({"done_count_", tag}, n_done, 1);
        check({"result_count_", tag}, n_res, NN);
        checking = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({"busy_", tag}, 32'(busy), 0);
        check({"done_", tag}, 32'(done), 0);
        check({"w_en_", tag}, 32'(w_en), 0);
        check({"a_en_", tag}, 32'(a_en), 0);
        check({"out_valid_", tag}, 32'(out_valid), 0);
        check({"w_addr_", tag}, 32'(w_addr), 0);
        check({"a_addr_", tag}, 32'(a_addr), 0);
        check({"out_idx_", tag}, 32'(out_idx), 0);
        check({"out_data_", tag}, 32'(out_data), 0);
    endtask

    initial begin
        load_mem(0);
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Unit weights, zero activations: each sum is 169 * 1.
        for (int k = 0; k < NN; k++) check("model_ones", 32'(exp_res[k]), 169);
        run_vector(514, 1'b0, "ones");
        for (int k = 0; k < NN; k++) check("got_ones", 32'(got[k]), 169);

        // Weights -1, activations 255: each sum is -256*169.
        load_mem(1);
        for (int k = 0; k < NN; k++) check("model_neg", 32'(exp_res[k]), 32'h00FF5700);
        run_vector(514, 1'b0, "neg");
        for (int k = 0; k < NN; k++) check("got_neg", 32'(got[k]), 32'h00FF5700);

        // Neuron-dependent weights, activations 1: (1+1)*(n+1)*169.
        load_mem(2);
        check("model_ramp0", 32'(exp_res[0]), 338);
        check("model_ramp1", 32'(exp_res[1]), 676);
        check("model_ramp2", 32'(exp_res[2]), 1014);
        run_vector(514, 1'b0, "ramp");
        check("got_ramp0", 32'(got[0]), 338);
        check("got_ramp1", 32'(got[1]), 676);
        check("got_ramp2", 32'(got[2]), 1014);

        // Backpressure: 10 stalled cycles per result.
        stall_mode = 1'b1;
        run_vector(544, 1'b0, "stall");
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);
        check("got_stall0", 32'(got[0]), 338);
        check("got_stall2", 32'(got[2]), 1014);

        // Extra start during neuron 1 must be ignored.
        load_mem(0);
        run_vector(514, 1'b1, "restart");

        // Asynchronous reset in the middle of neuron 1.
        begin_vector();
        repeat (248) @(posedge clk);
        #1;
        check("busy_before_abort", 32'(busy), 1);
        check("reading_before_abort", 32'(w_en), 1);
        rst_n    = 1'b0;
        checking = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_vector(514, 1'b0, "after_abort");
        for (int k = 0; k < NN; k++) check("got_after_abort", 32'(got[k]), 169);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
